// File: rtl/pmem_pkg.sv
// Shared definitions for the program-memory loader and the core's halfword-indexed pmem.
package pmem_pkg;

    localparam int PMEM_DEPTH  = 1024;
    localparam int PMEM_ADDR_W = 10;

    // Frame header carries the halfword count as LEN_BYTES little-endian bytes.
    localparam int LEN_BYTES = 2;
    localparam int LEN_W     = 8 * LEN_BYTES;

    typedef enum logic [2:0] {
        S_LEN_LO  = 3'd0,
        S_LEN_HI  = 3'd1,
        S_DATA_LO = 3'd2,
        S_DATA_HI = 3'd3,
        S_CHK     = 3'd4,
        S_DONE    = 3'd5
    } state_t;

endpackage

// File: rtl/pmem_loader.sv
// Framed byte-stream loader: assembles halfwords into program memory and holds the
// core in reset until a frame with a matching XOR checksum has been received.
module pmem_loader
    import pmem_pkg::*;
#(
    parameter int DEPTH  = PMEM_DEPTH,
    parameter int ADDR_W = PMEM_ADDR_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [15:0]       wr_data,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam logic [LEN_W:0] DEPTH_LIMIT = (LEN_W + 1)'(DEPTH);

    state_t              state_q;
    logic [LEN_W-1:0]    len_q;
    logic [LEN_W-1:0]    idx_q;
    logic [7:0]          lo_q;
    logic [7:0]          acc_q;
    logic                oversize_q;
    logic                wr_en_q;
    logic [ADDR_W-1:0]   wr_addr_q;
    logic [15:0]         wr_data_q;
    logic                cpu_reset_q;
    logic                busy_q;
    logic                done_q;
    logic                error_q;

    logic                accept;
    logic [7:0]          acc_d;
    logic [LEN_W-1:0]    idx_d;
    logic [LEN_W-1:0]    len_d;
    logic                in_range;
    logic                last_hw;
    logic                error_d;

    assign in_ready = (state_q != S_DONE);
    assign accept   = in_valid && in_ready;

    always_comb begin
        acc_d    = acc_q ^ in_data;
        idx_d    = idx_q + 1'b1;
        len_d    = {in_data, len_q[7:0]};
        in_range = ({1'b0, idx_q} < DEPTH_LIMIT);
        // idx_q + 1 never exceeds len_q, so the 16-bit sum cannot wrap here.
        last_hw  = (idx_d == len_q);
        error_d  = (acc_q != in_data) || oversize_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_LEN_LO;
            len_q       <= '0;
            idx_q       <= '0;
            lo_q        <= '0;
            acc_q       <= '0;
            oversize_q  <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            cpu_reset_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
            unique case (state_q)
                S_LEN_LO: begin
                    if (accept) begin
                        len_q[7:0]  <= in_data;
                        idx_q       <= '0;
                        acc_q       <= '0;
                        oversize_q  <= 1'b0;
                        cpu_reset_q <= 1'b1;
                        error_q     <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= S_LEN_HI;
                    end
                end
                S_LEN_HI: begin
                    if (accept) begin
                        len_q   <= len_d;
                        state_q <= (len_d != '0) ? S_DATA_LO : S_CHK;
                    end
                end
                S_DATA_LO: begin
                    if (accept) begin
                        lo_q    <= in_data;
                        acc_q   <= acc_d;
                        state_q <= S_DATA_HI;
                    end
                end
                S_DATA_HI: begin
                    if (accept) begin
                        acc_q <= acc_d;
                        idx_q <= idx_d;
                        // Out-of-range halfwords are still consumed so the checksum stays aligned.
                        if (in_range) begin
                            wr_en_q   <= 1'b1;
                            wr_addr_q <= idx_q[ADDR_W-1:0];
                            wr_data_q <= {in_data, lo_q};
                        end else begin
                            oversize_q <= 1'b1;
                        end
                        state_q <= last_hw ? S_CHK : S_DATA_LO;
                    end
                end
                S_CHK: begin
                    if (accept) begin
                        error_q     <= error_d;
                        cpu_reset_q <= error_d;
                        done_q      <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_q <= S_LEN_LO;
                end
                default: begin
                    state_q <= S_LEN_LO;
                end
            endcase
        end
    end

    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign cpu_reset = cpu_reset_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;

endmodule

// File: tb/tb_pmem_loader.sv
// Randomized self-checking bench for pmem_loader against a frame-level reference model.
module tb_pmem_loader;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        wr_en;
    logic [9:0]  wr_addr;
    logic [15:0] wr_data;
    logic        cpu_reset;
    logic        busy;
    logic        done;
    logic        error;

    pmem_loader dut (
        .clock     (clock),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .cpu_reset (cpu_reset),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int nvec = 0;
    int nerr = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {int cyc; logic [9:0] a; logic [15:0] d;} wrec_t;
    typedef struct {int cyc; logic err; logic cr; logic bsy; logic rdy;} drec_t;
    typedef struct {int pos; logic [9:0] a; logic [15:0] d;} ewr_t;
    typedef struct {int pos; logic err; int n;} edone_t;

    wrec_t wq[$];
    drec_t dq[$];

    // Observed write and done events, stamped with the clock edge that produced them.
    always @(negedge clock) begin
        if (!reset) begin
            if (wr_en) wq.push_back('{cyc, wr_addr, wr_data});
            if (done)  dq.push_back('{cyc, error, cpu_reset, busy, in_ready});
        end
    end

    task automatic check_reset_values();
        check("rst_in_ready",  {31'd0, in_ready},  32'd1);
        check("rst_wr_en",     {31'd0, wr_en},     32'd0);
        check("rst_wr_addr",   {22'd0, wr_addr},   32'd0);
        check("rst_wr_data",   {16'd0, wr_data},   32'd0);
        check("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        check("rst_busy",      {31'd0, busy},      32'd0);
        check("rst_done",      {31'd0, done},      32'd0);
        check("rst_error",     {31'd0, error},     32'd0);
    endtask

    task automatic apply_reset();
        in_valid = 1'b0;
        reset    = 1'b1;
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;
        check_reset_values();
    endtask

    // Offers one byte after an optional idle gap; returns the edge on which it was accepted.
    task automatic send_byte(input logic [7:0] b, input int maxgap, output int edge_no);
        int gap;
        int t;
        gap = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
        if (gap > 0) begin
            in_valid = 1'b0;
            repeat (gap) begin
                @(posedge clock);
                #1;
            end
        end
        in_valid = 1'b1;
        in_data  = b;
        t = 0;
        while (!in_ready && t < 20) begin
            @(posedge clock);
            #1;
            t++;
        end
        if (!in_ready) begin
            check("ready_timeout", 32'd0, 32'd1);
            edge_no = -1;
        end else begin
            @(posedge clock);
            #1;
            edge_no = cyc;
        end
    endtask

    task automatic run_stream(input logic [7:0] bs[$], input int maxgap);
        ewr_t   ew[$];
        edone_t ed[$];
        int     edges[$];
        bit     is_lenlo[int];
        int     lenlo_list[$];
        int     p;
        int     n;
        int     e;
        int     wi;
        logic [7:0] acc;

        p = 0;
        while (p + 2 <= bs.size()) begin
            n = {16'd0, bs[p+1], bs[p]};
            is_lenlo[p] = 1'b1;
            lenlo_list.push_back(p);
            p += 2;
            acc = 8'h00;
            for (int i = 0; i < n; i++) begin
                acc ^= bs[p] ^ bs[p+1];
                if (i < 1024) ew.push_back('{p + 1, i[9:0], {bs[p+1], bs[p]}});
                p += 2;
            end
            ed.push_back('{p, (acc != bs[p]) || (n > 1024), n});
            p++;
        end

        wq.delete();
        dq.delete();
        for (int k = 0; k < bs.size(); k++) begin
            send_byte(bs[k], maxgap, e);
            edges.push_back(e);
            if (is_lenlo.exists(k)) begin
                check("lenlo_cpu_reset", {31'd0, cpu_reset}, 32'd1);
                check("lenlo_error",     {31'd0, error},     32'd0);
                check("lenlo_busy",      {31'd0, busy},      32'd1);
            end
        end
        in_valid = 1'b0;
        repeat (3) @(posedge clock);
        #1;

        check("write_count", wq.size(), ew.size());
        check("done_count",  dq.size(), ed.size());
        for (int k = 0; k < ew.size() && k < wq.size(); k++) begin
            check("wr_addr",  {22'd0, wq[k].a}, {22'd0, ew[k].a});
            check("wr_data",  {16'd0, wq[k].d}, {16'd0, ew[k].d});
            check("wr_cycle", wq[k].cyc, edges[ew[k].pos]);
        end
        for (int k = 0; k < ed.size() && k < dq.size(); k++) begin
            check("done_cycle",     dq[k].cyc, edges[ed[k].pos]);
            check("done_error",     {31'd0, dq[k].err}, {31'd0, ed[k].err});
            check("done_cpu_reset", {31'd0, dq[k].cr},  {31'd0, ed[k].err});
            check("done_busy",      {31'd0, dq[k].bsy}, 32'd0);
            check("done_in_ready",  {31'd0, dq[k].rdy}, 32'd0);
            if (maxgap == 0 && k + 1 < ed.size())
                check("boundary_stall", edges[lenlo_list[k+1]], edges[ed[k].pos] + 2);
        end
        wi = 0;
        foreach (ed[k]) begin
            $display("frame N=%0d expected_error=%0d writes=%0d gap=%0d",
                     ed[k].n, ed[k].err, (ed[k].n > 1024) ? 1024 : ed[k].n, maxgap);
            wi++;
        end
    endtask

    initial begin
        logic [7:0] s[$];
        int         e;
        int         n;
        logic [7:0] acc;
        logic [7:0] b;

        apply_reset();

        s = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h93, 8'h05, 8'h80};
        run_stream(s, 0);

        s = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h93, 8'h05, 8'h81};
        run_stream(s, 0);

        s = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33};
        run_stream(s, 0);

        s = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h93, 8'h05, 8'h80};
        run_stream(s, 3);

        // Reset in the middle of the second halfword must not produce a write.
        wq.delete();
        s = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h93};
        foreach (s[k]) send_byte(s[k], 0, e);
        in_valid = 1'b0;
        apply_reset();
        check("partial_writes", wq.size(), 1);
        s = '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'h11};
        run_stream(s, 0);

        for (int it = 0; it < 6; it++) begin
            s.delete();
            for (int f = 0; f < int'($urandom_range(1, 3)); f++) begin
                n = int'($urandom_range(0, 5));
                s.push_back(n[7:0]);
                s.push_back(8'h00);
                acc = 8'h00;
                for (int i = 0; i < 2 * n; i++) begin
                    b = 8'($urandom);
                    acc ^= b;
                    s.push_back(b);
                end
                if ($urandom_range(0, 2) == 0) acc ^= 8'h01;
                s.push_back(acc);
            end
            run_stream(s, int'($urandom_range(0, 2)));
        end

        s.delete();
        s.push_back(8'h01);
        s.push_back(8'h04);
        for (int i = 0; i < 2050; i++) s.push_back(8'h00);
        s.push_back(8'h00);
        run_stream(s, 0);
        check("oversize_error_held", {31'd0, error},     32'd1);
        check("oversize_cpu_reset",  {31'd0, cpu_reset}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/pmem_loader.md
# pmem_loader

Program-memory writer for the RV32C core. It accepts a framed byte stream over a valid/ready handshake, assembles little-endian 16-bit halfwords and writes them into the instruction memory that the core fetches from (halfword-indexed, 1024 entries). It holds the core in reset while a load is in progress and releases it only after a load whose checksum matches.

## Interface
- DEPTH, 1024: number of halfword entries in program memory.
- ADDR_W, 10: halfword address width, equal to log2(DEPTH).
- clock  in  1  system clock. Reset: `reset`, synchronous, active-high; clock: `clock`.
- reset  in  1  synchronous active-high reset.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader accepts a byte. A byte transfers when in_valid && in_ready at the clock edge.
- wr_en  out  1  program-memory write strobe, one cycle per halfword.
- wr_addr  out  ADDR_W  halfword index to write (byte address >> 1).
- wr_data  out  16  halfword; low byte was received first.
- cpu_reset  out  1  high holds the core in reset.
- busy  out  1  a frame is partially received.
- done  out  1  one-cycle pulse at frame end.
- error  out  1  last frame bad (checksum mismatch or oversize). Holds until the next frame starts.

## Operation
- Frame format: LEN_LO, LEN_HI (N = halfword count, 16-bit little-endian), then 2N data bytes, each halfword sent low byte first, then one CHK byte. CHK is the XOR of all 2N data bytes; header bytes are excluded.
- States:
  - S_LEN_LO → S_LEN_HI on accept.
  - S_LEN_HI → S_DATA_LO if N≠0, else S_CHK.
  - S_DATA_LO → S_DATA_HI on accept.
  - S_DATA_HI → S_DATA_LO if halfwords received < N, else S_CHK.
  - S_CHK → S_DONE on accept.
  - S_DONE → S_LEN_LO unconditionally, after one cycle.
- in_ready is 1 in every state except S_DONE. A byte offered during S_DONE is not consumed and must be held by the source.
- Halfword index counter is 16 bits and starts at 0 each frame. A halfword with index < DEPTH is written at wr_addr = index[ADDR_W-1:0]. Index ≥ DEPTH: no write, the bytes are still consumed and XORed, and an oversize flag is set.
- An XOR accumulator clears on LEN_LO accept and folds in every data byte.
- At CHK accept: error ← (acc ≠ CHK) | oversize.
- Data already written is never rolled back on error.
- cpu_reset:
  - Set by reset and on LEN_LO accept.
  - Cleared only on CHK accept with error clear.
  - A bad frame leaves it at 1.
- busy = 1 from LEN_LO accept up to and including the CHK accept cycle; 0 in S_LEN_LO and S_DONE.
- Reset mid-frame: state → S_LEN_LO, counters and accumulator cleared, no write issued for a partial halfword, cpu_reset = 1, error = 0. The next accepted byte is treated as LEN_LO.

## Timing
- Reset values: in_ready = 1, wr_en = 0, wr_addr = 0, wr_data = 0, cpu_reset = 1, busy = 0, done = 0, error = 0.
- All outputs are registered except in_ready, which is decoded from state.
- Write latency: wr_en, wr_addr and wr_data are valid the cycle after the DATA_HI byte is accepted, for exactly one cycle.
- done, error and the cpu_reset release all appear together the cycle after CHK is accepted (state S_DONE).
- Throughput: one byte per cycle. A minimal frame (N = 0) spans 3 accepted bytes plus 1 S_DONE cycle.
- Gaps in in_valid stall the FSM with no side effects.

## Structure
- Shared package pmem_pkg holds:
  - FSM state encoding (S_LEN_LO, S_LEN_HI, S_DATA_LO, S_DATA_HI, S_CHK, S_DONE);
  - PMEM_DEPTH = 1024 and PMEM_ADDR_W = 10, shared with the core's pmem;
  - LEN_BYTES = 2.
- Single flat module; no sub-module is warranted. Write port semantics match the core's pmem: halfword index, 16-bit data.

## Test plan
- Bytes 02 00 13 05 93 05 80 → writes [0]=0x0513 and [1]=0x0593 on consecutive-accept+1 cycles; done pulse; error = 0; cpu_reset falls to 0 with done.
- Same frame with CHK = 81 → both writes still occur; error = 1; cpu_reset stays 1; done pulses.
- 00 00 00 → no wr_en; done at the 4th cycle; cpu_reset = 0. Then a new frame starting 01 … → cpu_reset = 1 the cycle after LEN_LO is accepted, and error from the previous frame is cleared.
- in_valid held high continuously across a frame boundary → in_ready = 0 for exactly one cycle (S_DONE); the next frame's LEN_LO is accepted the following cycle without loss. Random in_valid gaps produce identical writes.
- Reset asserted after 02 00 13 05 93 (mid-halfword) → no write of a second halfword. A following 01 00 AA BB 11 writes [0]=0xBBAA with error = 0.
- N = 1025 (01 04), all data bytes 00, CHK 00 → writes to 0..1023 only, none for index 1024; error = 1; cpu_reset stays 1.
